// File: rtl/sram_row_reader.sv
// Read-side initiator for the single-port row SRAM: reads NUM rows from BASE upward
// and streams them out on a valid/ready interface through a small output FIFO.
module sram_row_reader #(
  parameter int unsigned BWIDTH     = 256,
  parameter int unsigned AWIDTH     = 10,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START_in,
  input  logic [AWIDTH-1:0] BASE_ADDR_in,
  input  logic [AWIDTH:0]   NUM_ROWS_in,
  output logic              BUSY_out,
  output logic              DONE_out,
  output logic              CSn_out,
  output logic              WEn_out,
  output logic [AWIDTH-1:0] ADDR_out,
  output logic [BWIDTH-1:0] BE_out,
  output logic [BWIDTH-1:0] WDATA_out,
  input  logic [BWIDTH-1:0] RDATA_in,
  output logic              ROW_VALID_out,
  input  logic              ROW_READY_in,
  output logic [BWIDTH-1:0] ROW_DATA_out,
  output logic              ROW_LAST_out
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [AWIDTH:0]     issue_rem_q, issue_rem_d;
  logic [AWIDTH:0]     pop_rem_q, pop_rem_d;
  logic                pend_q, pend_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [BWIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [BWIDTH-1:0]   mem_d [FIFO_DEPTH];

  logic                valid;
  logic                pop;
  logic                issue;
  logic [CW:0]         committed;

  always_comb begin
    valid     = (count_q != '0);
    pop       = valid && ROW_READY_in;
    // Slots already owed: stored rows plus the in-flight read, minus the row leaving now.
    committed = {1'b0, count_q} + (CW+1)'(pend_q) - (CW+1)'(pop);
    issue     = (state_q == S_ISSUE) && (committed < (CW+1)'(FIFO_DEPTH));

    state_d     = state_q;
    addr_d      = addr_q;
    issue_rem_d = issue_rem_q;
    pop_rem_d   = pop_rem_q;
    pend_d      = issue;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q + CW'(pend_q) - CW'(pop);
    mem_d       = mem_q;

    if (pend_q) begin
      mem_d[wr_ptr_q] = RDATA_in;
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d  = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      pop_rem_d = pop_rem_q - (AWIDTH+1)'(1);
    end
    if (issue) begin
      addr_d      = addr_q + AWIDTH'(1);
      issue_rem_d = issue_rem_q - (AWIDTH+1)'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (START_in) begin
          addr_d      = BASE_ADDR_in;
          issue_rem_d = NUM_ROWS_in;
          pop_rem_d   = NUM_ROWS_in;
          if (NUM_ROWS_in == '0) state_d = S_DONE;
          else                   state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue && (issue_rem_q == (AWIDTH+1)'(1))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && (pop_rem_q == (AWIDTH+1)'(1))) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY_out      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    DONE_out      = (state_q == S_DONE);
    CSn_out       = !issue;
    WEn_out       = 1'b1;
    ADDR_out      = addr_q;
    BE_out        = '0;
    WDATA_out     = '0;
    ROW_VALID_out = valid;
    ROW_DATA_out  = mem_q[rd_ptr_q];
    ROW_LAST_out  = valid && (pop_rem_q == (AWIDTH+1)'(1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_rem_q <= '0;
      pop_rem_q   <= '0;
      pend_q      <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_rem_q <= issue_rem_d;
      pop_rem_q   <= pop_rem_d;
      pend_q      <= pend_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

endmodule
